// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the return-address stack.
package cpu_pkg;

    localparam int ADDR_W_DEF       = 8;
    localparam int RSTACK_DEPTH_DEF = 4;

    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage : cpu_pkg

// File: rtl/return_stack_mem.sv
// Return-stack register file: DEPTH entries cleared on reset,
// one synchronous write port and one combinational read port.
module return_stack_mem
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = RSTACK_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [ADDR_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [ADDR_W-1:0] rdata_o
);

    logic [ADDR_W-1:0] entry_q [DEPTH];

    // Entries stay registers rather than block RAM: the read is same-cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_q[gi] <= '0;
                end else if (we_i && (waddr_i == PTR_W'(gi))) begin
                    entry_q[gi] <= wdata_i;
                end
            end
        end
    endgenerate

    assign rdata_o = entry_q[raddr_i];

endmodule : return_stack_mem

// File: rtl/return_stack.sv
// Return-address stack: pointer, occupancy and flag logic around the entry file.
// Define RETURN_STACK_GUARD_EN to ignore overflow/underflow and raise sticky ovf/unf.
module return_stack
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = RSTACK_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] ret_in,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              unf
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  top_ptr;
    logic [ADDR_W-1:0] rdata;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign top_ptr = sp_q - ONE_P;
    assign top     = empty ? '0 : rdata;

`ifdef RETURN_STACK_GUARD_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push && pop && !empty) begin
            we    = 1'b1;
            waddr = top_ptr;
        end else if (push) begin
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                we      = 1'b1;
                sp_d    = sp_q + ONE_P;
                count_d = count_q + ONE_C;
            end
        end else if (pop) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                sp_d    = top_ptr;
                count_d = count_q - ONE_C;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`else
    // Circular behaviour: pointer always moves, count saturates at both ends.
    always_comb begin
        sp_d    = sp_q;
        count_d = count_q;
        we      = 1'b0;
        waddr   = sp_q;
        if (push && pop && !empty) begin
            we    = 1'b1;
            waddr = top_ptr;
        end else if (push) begin
            we   = 1'b1;
            sp_d = sp_q + ONE_P;
            if (!full) count_d = count_q + ONE_C;
        end else if (pop) begin
            sp_d = top_ptr;
            if (!empty) count_d = count_q - ONE_C;
        end
    end

    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q    <= '0;
            count_q <= '0;
        end else begin
            sp_q    <= sp_d;
            count_q <= count_d;
        end
    end

    return_stack_mem #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (ret_in),
        .raddr_i (top_ptr),
        .rdata_o (rdata)
    );

endmodule : return_stack

// File: tb/tb_return_stack.sv
// Directed self-checking bench for return_stack (DEPTH=4, ADDR_W=8).
// Expectations follow RETURN_STACK_GUARD_EN when it is defined.
module tb_return_stack;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] ret_in = 8'h00;
    logic [7:0] top;
    logic       empty, full, ovf, unf;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    return_stack #(.ADDR_W(8), .DEPTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .ret_in (ret_in),
        .top    (top),
        .empty  (empty),
        .full   (full),
        .count  (count),
        .ovf    (ovf),
        .unf    (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [7:0] d);
        push   = p;
        pop    = q;
        ret_in = d;
        @(posedge clk);
        #1;
        $display("step push=%0d pop=%0d ret_in=%h -> top=%h count=%0d ovf=%0d unf=%0d",
                 p, q, d, top, count, ovf, unf);
        push   = 1'b0;
        pop    = 1'b0;
        ret_in = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // 1. reset then idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        chk("reset_top",   top,   0);
        chk("reset_empty", empty, 1);
        chk("reset_full",  full,  0);
        chk("reset_count", count, 0);
        chk("reset_ovf",   ovf,   0);
        chk("reset_unf",   unf,   0);

        // 2. push three, pop two
        step(1'b1, 1'b0, 8'h12);
        chk("push1_top", top, 8'h12);
        step(1'b1, 1'b0, 8'h34);
        step(1'b1, 1'b0, 8'h56);
        chk("push3_top",   top,   8'h56);
        chk("push3_count", count, 3);
        step(1'b0, 1'b1, 8'h00);
        chk("pop1_top", top, 8'h34);
        step(1'b0, 1'b1, 8'h00);
        chk("pop2_top",   top,   8'h12);
        chk("pop2_count", count, 1);

        // 3. overflow: push 0x01..0x05
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i));
        chk("fill_full", full, 1);
        step(1'b1, 1'b0, 8'h05);
        chk("ovf_count", count, 4);
        chk("ovf_full",  full,  1);
`ifdef RETURN_STACK_GUARD_EN
        chk("ovf_flag", ovf, 1);
        chk("ovf_top",  top, 8'h04);
`else
        chk("ovf_flag", ovf, 0);
        chk("ovf_top",  top, 8'h05);
        chk("wrap_pop_a", top, 8'h05); step(1'b0, 1'b1, 8'h00);
        chk("wrap_pop_b", top, 8'h04); step(1'b0, 1'b1, 8'h00);
        chk("wrap_pop_c", top, 8'h03); step(1'b0, 1'b1, 8'h00);
        chk("wrap_pop_d", top, 8'h02); step(1'b0, 1'b1, 8'h00);
        chk("wrap_empty", empty, 1);
        chk("wrap_top0",  top,   0);
`endif

        // 4. pop from empty
        do_reset();
        chk("rst_clr_ovf", ovf, 0);
        step(1'b0, 1'b1, 8'h00);
        chk("unf_count", count, 0);
        chk("unf_top",   top,   0);
        chk("unf_empty", empty, 1);
`ifdef RETURN_STACK_GUARD_EN
        chk("unf_flag", unf, 1);
        step(1'b0, 1'b0, 8'h00);
        chk("unf_sticky", unf, 1);
`else
        chk("unf_flag", unf, 0);
`endif
        step(1'b1, 1'b0, 8'h3C);
        chk("after_unf_top",   top,   8'h3C);
        chk("after_unf_count", count, 1);

        // 5. simultaneous push+pop replaces top; on empty acts as push
        do_reset();
        step(1'b1, 1'b1, 8'h11);
        chk("pp_empty_top",   top,   8'h11);
        chk("pp_empty_count", count, 1);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h20);
        step(1'b1, 1'b1, 8'h77);
        chk("replace_top",   top,   8'h77);
        chk("replace_count", count, 1);
        step(1'b0, 1'b1, 8'h00);
        chk("replace_pop_empty", empty, 1);

        // 6. asynchronous reset mid-cycle, then strobe on first edge after release
        step(1'b1, 1'b0, 8'hAA);
        step(1'b1, 1'b0, 8'hBB);
        chk("pre_rst_top", top, 8'hBB);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_top",   top,   0);
        chk("async_rst_count", count, 0);
        chk("async_rst_empty", empty, 1);
        #2;
        rst    = 1'b0;
        push   = 1'b1;
        ret_in = 8'h42;
        @(posedge clk);
        #1;
        $display("step push=1 pop=0 ret_in=42 (first edge after reset) -> top=%h count=%0d", top, count);
        push   = 1'b0;
        ret_in = 8'h00;
        chk("post_rst_top",   top,   8'h42);
        chk("post_rst_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_return_stack
